// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared definitions for the UART TX arbiter.
//   - arb_state_t and its state encodings (plain localparams for legacy tools)
//   - HDR_TAG: upper bits of the header byte sent ahead of each payload
//   - num_req_ok(): legal range check for the requester count
package uart_arb_pkg;

    typedef logic [2:0] arb_state_t;

    localparam arb_state_t StIdle     = 3'd0;
    localparam arb_state_t StHdrStart = 3'd1;
    localparam arb_state_t StHdrWait  = 3'd2;
    localparam arb_state_t StDatStart = 3'd3;
    localparam arb_state_t StDatWait  = 3'd4;

    localparam logic [7:0] HDR_TAG = 8'hA0;

    localparam int unsigned NumReqMin = 2;
    localparam int unsigned NumReqMax = 16;

    // The header carries the index in its low nibble, so 16 is a hard ceiling.
    function automatic bit num_req_ok(input int unsigned n);
        return (n >= NumReqMin) && (n <= NumReqMax);
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// uart_rr_pick: combinational round-robin selector.
//   req_valid  in  NUM_REQ  per-requester request
//   last_grant in  IDX_W    index granted most recently
//   any_valid  out 1        at least one request is pending
//   winner     out IDX_W    first valid index after last_grant (wrapping)
module uart_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [IDX_W-1:0]   last_grant,
    output logic               any_valid,
    output logic [IDX_W-1:0]   winner
);

    int               sum;
    logic [IDX_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest valid index wins.
    always_comb begin
        any_valid = |req_valid;
        winner    = '0;
        sum       = 0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            sum = int'(last_grant) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            cand = sum[IDX_W-1:0];
            if (req_valid[cand]) begin
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ
// byte producers, all in the uart_clk domain.
//   uart_clk   in  1                   clock
//   rst_n      in  1                   asynchronous active-low reset
//   req_valid  in  NUM_REQ             per-requester byte available
//   req_data   in  NUM_REQ*DATA_WIDTH  packed bytes, requester i at [i*DW +: DW]
//   req_ready  out NUM_REQ             one-hot pulse: that requester's byte is taken
//   tx_start   out 1                   one-cycle frame launch
//   tx_data    out DATA_WIDTH          byte for the transmitter, stable until tx_done
//   tx_done    in  1                   frame complete pulse
//   grant_id   out IDX_W               current owner of the transmitter
//   arb_busy   out 1                   high whenever not IDLE
// Build option: define UART_TX_ARB_HDR_EN to precede every payload with a
// header frame (HDR_TAG | grant_id).
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int IDX_W      = $clog2(NUM_REQ)
) (
    input  logic                          uart_clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          tx_start,
    output logic [DATA_WIDTH-1:0]         tx_data,
    input  logic                          tx_done,
    output logic [IDX_W-1:0]              grant_id,
    output logic                          arb_busy
);

    if (!num_req_ok(NUM_REQ)) begin : g_num_req_bad
        $error("uart_tx_arbiter: NUM_REQ must be within 2..16");
    end

    arb_state_t              state_q, state_d;
    logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
    logic [IDX_W-1:0]        last_grant_q, last_grant_d;
    logic [IDX_W-1:0]        grant_id_q, grant_id_d;
    logic [DATA_WIDTH-1:0]   pend_data_q, pend_data_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;

    logic                    any_valid;
    logic [IDX_W-1:0]        winner;
    logic                    arb_en;
    logic [DATA_WIDTH-1:0]   first_byte;
    logic [DATA_WIDTH-1:0]   req_bytes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_bytes[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .req_valid  (req_valid),
        .last_grant (last_grant_q),
        .any_valid  (any_valid),
        .winner     (winner)
    );

    // First byte on the wire for a new grant: header, or the payload itself.
`ifdef UART_TX_ARB_HDR_EN
    logic [7:0] hdr8;
    assign hdr8 = HDR_TAG | 8'(last_grant_q);
    if (DATA_WIDTH > 8) begin : g_hdr_wide
        assign first_byte = {{(DATA_WIDTH - 8){1'b0}}, hdr8};
    end else begin : g_hdr_narrow
        assign first_byte = hdr8[DATA_WIDTH-1:0];
    end
`else
    assign first_byte = pend_data_q;
`endif

    // req_ready_q doubles as "grant pending": the IDLE cycle that shows the
    // pulse launches the frame on its closing edge instead of re-arbitrating.
    always_comb begin
        state_d      = state_q;
        req_ready_d  = '0;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;
        pend_data_d  = pend_data_q;
        tx_data_d    = tx_data_q;
        arb_en       = 1'b0;

        case (state_q)
            StIdle: begin
                if (req_ready_q != '0) begin
                    grant_id_d = last_grant_q;
                    tx_data_d  = first_byte;
`ifdef UART_TX_ARB_HDR_EN
                    state_d    = StHdrStart;
`else
                    state_d    = StDatStart;
`endif
                end else begin
                    arb_en = 1'b1;
                end
            end
            StHdrStart: begin
`ifdef UART_TX_ARB_HDR_EN
                state_d = StHdrWait;
`else
                state_d = StIdle;
`endif
            end
            StHdrWait: begin
`ifdef UART_TX_ARB_HDR_EN
                if (tx_done) begin
                    tx_data_d = pend_data_q;
                    state_d   = StDatStart;
                end
`else
                state_d = StIdle;
`endif
            end
            StDatStart: begin
                state_d = StDatWait;
            end
            StDatWait: begin
                // Arbitrate on the done edge so the next pulse lands at D+1.
                if (tx_done) begin
                    state_d = StIdle;
                    arb_en  = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (arb_en && any_valid) begin
            req_ready_d[winner] = 1'b1;
            last_grant_d        = winner;
            pend_data_d         = req_bytes[winner];
        end
    end

    always_ff @(posedge uart_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            req_ready_q  <= '0;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            grant_id_q   <= '0;
            pend_data_q  <= '0;
            tx_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            req_ready_q  <= req_ready_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            pend_data_q  <= pend_data_d;
            tx_data_q    <= tx_data_d;
        end
    end

    assign req_ready = req_ready_q;
    assign tx_start  = (state_q == StDatStart) || (state_q == StHdrStart);
    assign tx_data   = tx_data_q;
    assign grant_id  = grant_id_q;
    assign arb_busy  = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed stimulus, expected grants
// and frames queued at issue time, a negedge monitor pops and compares.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
`ifdef UART_TX_ARB_HDR_EN
    localparam int FPG = 2;
`else
    localparam int FPG = 1;
`endif

    logic        uart_clk  = 1'b0;
    logic        rst_n     = 1'b0;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data  = '0;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_done   = 1'b0;
    logic [1:0]  grant_id;
    logic        arb_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int n_start = 0;
    int n_ready = 0;

    int         exp_grant [$];
    logic [7:0] exp_frame [$];

    uart_tx_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .uart_clk  (uart_clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_start  (tx_start),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .grant_id  (grant_id),
        .arb_busy  (arb_busy)
    );

    always #5 uart_clk = ~uart_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_expect(input int id, input logic [7:0] d);
        exp_grant.push_back(id);
`ifdef UART_TX_ARB_HDR_EN
        exp_frame.push_back(8'hA0 | 8'(id));
`endif
        exp_frame.push_back(d);
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a grant or a start.
    initial begin
        int         e;
        logic [7:0] f;
        logic [3:0] m;
        forever begin
            @(negedge uart_clk);
            if (rst_n) begin
                if (req_ready != 4'b0) begin
                    n_ready++;
                    if (exp_grant.size() == 0) begin
                        check("unexpected_req_ready", {28'b0, req_ready}, 32'h0);
                    end else begin
                        e = exp_grant.pop_front();
                        m = 4'b0001 << e;
                        check("req_ready_onehot", {28'b0, req_ready}, {28'b0, m});
                    end
                end
                if (tx_start) begin
                    n_start++;
                    if (exp_frame.size() == 0) begin
                        check("unexpected_tx_start", {31'b0, tx_start}, 32'h0);
                    end else begin
                        f = exp_frame.pop_front();
                        check("tx_data_at_start", {24'b0, tx_data}, {24'b0, f});
                    end
                end
            end
        end
    end

    task automatic wait_for_start(input string tag);
        int n = 0;
        while (tx_start !== 1'b1 && n < 200) begin
            @(negedge uart_clk);
            n++;
        end
        check({"tx_start_seen_", tag}, {31'b0, tx_start}, 32'h1);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (req_ready === 4'b0 && n < 200) begin
            @(negedge uart_clk);
            n++;
        end
        check({"req_ready_seen_", tag}, {31'b0, (req_ready !== 4'b0)}, 32'h1);
    endtask

    task automatic pulse_done();
        tx_done = 1'b1;
        @(negedge uart_clk);
        tx_done = 1'b0;
    endtask

    // Serve every frame of one grant; valid_after is applied before the last done.
    task automatic do_transfer(input logic [3:0] valid_after);
        for (int f = 0; f < FPG; f++) begin
            wait_for_start("xfer");
            @(negedge uart_clk);
            if (f == FPG - 1) req_valid = valid_after;
            pulse_done();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req_ready"}, {28'b0, req_ready}, 32'h0);
        check({tag, "_tx_start"},  {31'b0, tx_start},  32'h0);
        check({tag, "_tx_data"},   {24'b0, tx_data},   32'h0);
        check({tag, "_grant_id"},  {30'b0, grant_id},  32'h0);
        check({tag, "_arb_busy"},  {31'b0, arb_busy},  32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] first_exp;
        int         r0;
        int         s0;

        // Reset values
        repeat (2) @(negedge uart_clk);
        check_all_zero("reset");
        rst_n = 1'b1;
        @(negedge uart_clk);

        // Single request from 2, tx_done during start ignored, 10-cycle hold
`ifdef UART_TX_ARB_HDR_EN
        first_exp = 8'hA2;
`else
        first_exp = 8'h5A;
`endif
        push_expect(2, 8'h5A);
        req_data[23:16] = 8'h5A;
        req_valid = 4'b0100;
        wait_ready("single");
        req_valid = 4'b0000;
        wait_for_start("single");
        check("single_grant_id", {30'b0, grant_id}, 32'd2);
        check("single_busy", {31'b0, arb_busy}, 32'h1);
        tx_done = 1'b1;
        @(negedge uart_clk);
        tx_done = 1'b0;
        check("start_one_cycle", {31'b0, tx_start}, 32'h0);
        check("done_in_start_ignored", {31'b0, arb_busy}, 32'h1);
        for (int i = 0; i < 10; i++) begin
            @(negedge uart_clk);
            check("tx_data_hold", {24'b0, tx_data}, {24'b0, first_exp});
        end
        pulse_done();
        for (int f = 1; f < FPG; f++) begin
            wait_for_start("single_payload");
            @(negedge uart_clk);
            pulse_done();
        end
        check("single_idle_after_done", {31'b0, arb_busy}, 32'h0);

        // Round robin from reset, all four continuously valid
        rst_n = 1'b0;
        @(negedge uart_clk);
        rst_n = 1'b1;
        r0 = n_ready;
        s0 = n_start;
        req_data = 32'h13121110;
        for (int k = 0; k < 8; k++) push_expect(k % 4, 8'h10 + 8'(k % 4));
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) do_transfer((k == 7) ? 4'b0000 : 4'b1111);
        repeat (3) @(negedge uart_clk);
        check("rr_ready_count", n_ready - r0, 32'd8);
        check("rr_start_count", n_start - s0, 32'd8 * FPG);
        check("rr_drained", exp_grant.size(), 32'd0);

        // Reset in the wait state, release with 1 and 3 valid
        push_expect(0, 8'h77);
        req_data = 32'h00000077;
        req_valid = 4'b0001;
        wait_ready("pre_reset");
        req_valid = 4'b0000;
        wait_for_start("pre_reset");
        @(negedge uart_clk);
        rst_n = 1'b0;
        req_data = 32'h33003100;
        req_valid = 4'b1010;
        @(negedge uart_clk);
        check_all_zero("mid_reset");
        push_expect(1, 8'h31);
        rst_n = 1'b1;
        wait_ready("post_reset");
        push_expect(3, 8'h33);
        do_transfer(4'b1000);
        do_transfer(4'b0000);

        // Requester 3 with 0x11: one ready, FPG starts
        r0 = n_ready;
        s0 = n_start;
        push_expect(3, 8'h11);
        req_data = 32'h11000000;
        req_valid = 4'b1000;
        wait_ready("req3");
        req_valid = 4'b0000;
        do_transfer(4'b0000);
        @(negedge uart_clk);
        check("req3_ready_count", n_ready - r0, 32'd1);
        check("req3_start_count", n_start - s0, 32'(FPG));

        // Requester 0 drops valid after its ready; byte still sent, no regrant
        r0 = n_ready;
        push_expect(0, 8'hC0);
        req_data = 32'h0000C1C0;
        req_valid = 4'b0011;
        wait_ready("drop");
        req_valid = 4'b0010;
        push_expect(1, 8'hC1);
        do_transfer(4'b0010);
        do_transfer(4'b0000);
        repeat (5) @(negedge uart_clk);
        check("drop_ready_count", n_ready - r0, 32'd2);
        check("drop_idle", {31'b0, arb_busy}, 32'h0);
        check("final_grants_drained", exp_grant.size(), 32'd0);
        check("final_frames_drained", exp_frame.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single UART transmitter among `NUM_REQ` byte-producing requesters. It accepts one byte at a time from the granted requester over a valid/ready handshake. It sequences the transmitter with a one-cycle start pulse and waits for the frame-complete pulse before arbitrating again. It sits between the application-side producers and the UART transmitter, all in the `uart_clk` domain, mirroring the receive path on the TX side.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 8: payload width; must match the transmitter.
- `IDX_W`, `$clog2(NUM_REQ)`: derived width of a requester index; do not override.

Ports:
- `uart_clk` in 1: the single clock (115200 Hz UART bit clock).
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ`: per-requester byte available.
- `req_data` in `NUM_REQ*DATA_WIDTH`: packed bytes; requester i occupies `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready` out `NUM_REQ`: one-hot, one-cycle pulse; the byte of that requester is consumed this cycle.
- `tx_start` out 1: one-cycle pulse that launches a frame on the transmitter.
- `tx_data` out `DATA_WIDTH`: byte to transmit; held stable from `tx_start` until `tx_done`.
- `tx_done` in 1: one-cycle pulse from the transmitter when the stop bit completes.
- `grant_id` out `IDX_W`: index of the requester that currently owns the transmitter.
- `arb_busy` out 1: high in every state except IDLE.

## Operation
- States: IDLE, HDR_START, HDR_WAIT, DAT_START, DAT_WAIT. The HDR_* states exist only with the configuration macro defined.
- **IDLE**
  - If any `req_valid` is high, select a winner by round-robin. The search starts at `last_grant+1` (mod `NUM_REQ`) and takes the first valid index.
  - Latch the winner's byte into `tx_data`, pulse `req_ready[winner]`, and set `grant_id` and `last_grant` to the winner.
  - Go to DAT_START, or to HDR_START when the header feature is compiled in.
- **\*_START**: assert `tx_start` for exactly one cycle, then go to the matching \*_WAIT state.
- **HDR_WAIT**: on `tx_done`, load the latched payload into `tx_data` and go to DAT_START.
- **DAT_WAIT**: on `tx_done`, go to IDLE.
- `tx_done` is ignored in IDLE and in the \*_START states.
- A requester whose `req_valid` drops after its `req_ready` pulse has no effect; the byte is already captured.
- New `req_valid` assertions during a transfer wait for the next IDLE arbitration.
- Fairness: a requester that holds `req_valid` high is granted within `NUM_REQ` transfers.

Reset values (any time, including mid-frame):
- `req_ready`=0, `tx_start`=0, `tx_data`=0, `grant_id`=0, `arb_busy`=0, state=IDLE.
- `last_grant`=`NUM_REQ-1`, so requester 0 has first priority after reset.
- A frame that is in flight at reset is abandoned; no `req_ready` is re-issued.

## Timing
- Cycle T (IDLE, valid seen): `req_ready` pulses; `tx_data` and `grant_id` update at the T+1 edge.
- Cycle T+1: `tx_start`=1.
- From T+2: wait for `tx_done`. If `tx_done` arrives at cycle D, state is IDLE at D+1, and the earliest next `req_ready` is at D+1.
- With the header feature: the header `tx_start` is at T+1; the payload `tx_start` is one cycle after the header's `tx_done`.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `UART_TX_ARB_HDR_EN`.
- Defined:
  - Each grant sends two frames: a header byte, then the payload.
  - Header byte = `8'hA0 | grant_id`, truncated or zero-extended to `DATA_WIDTH`.
  - Requires `NUM_REQ` ≤ 16.
- Undefined:
  - HDR_START and HDR_WAIT are absent; only the payload frame is sent.

## Structure
- Shared package `uart_arb_pkg` holds:
  - the state enum;
  - the `HDR_TAG` constant (`8'hA0`);
  - the `NUM_REQ` range check.
- Sub-module `uart_rr_pick`: combinational round-robin selector.
  - Inputs: `req_valid`, `last_grant`.
  - Outputs: `any_valid`, `winner` index.

## Test plan
- Single request: reset, `req_valid`=4'b0100 with data 8'h5A → `req_ready`=4'b0100 for 1 cycle, `tx_start` next cycle, `tx_data`=8'h5A, `grant_id`=2; `tx_done` → `arb_busy`=0.
- Round-robin: all four valid continuously, 8 transfers → grant order 0,1,2,3,0,1,2,3, and exactly one `req_ready` pulse per transfer.
- Hold and ignore:
  - `tx_done` pulsed during a \*_START cycle → ignored; the state still waits for the next `tx_done`.
  - `tx_data` is constant for a 10-cycle wait.
- Reset mid-frame: assert `rst_n`=0 in DAT_WAIT, then release with requesters 1 and 3 valid → all outputs 0 during reset; the first grant after release goes to 1.
- `UART_TX_ARB_HDR_EN` defined, requester 3 sends 8'h11 → frames 8'hA3 then 8'h11, with two `tx_start` pulses and one `req_ready`.
- Valid dropped after ready: requester 0 deasserts `req_valid` the cycle after `req_ready` → its byte is still transmitted, and no further grant goes to 0.
